in_feature_loader: RTL and testbench
====================================

// Module: in_feature_loader
// PURPOSE
//  Upstream stage of the CNN top level. Accepts one input frame as a valid/ready pixel
//  stream and packs pixel pairs into the dual-port in_feature RAM (port a even addr,
//  port b odd addr). Then holds the network enable until the final layer reports done.
//  Drives the RAM data/address/write-enable that the top level currently leaves unassigned.
// PARAMETERS
//  DATA_WIDTH   16   pixel / RAM word width
//  ADDR_WIDTH   9    in_feature RAM address width
//  NUM_PIXELS   400  pixels per frame; 1..2**ADDR_WIDTH, odd values allowed
// PORTS
//  clock        in   1           system clock, all logic on rising edge
//  reset        in   1           synchronous, active-high reset
//  start        in   1           1-cycle pulse: begin loading a frame (honoured in IDLE only)
//  pix_valid    in   1           input pixel valid
//  pix_data     in   DATA_WIDTH  input pixel, raster order
//  pix_ready    out  1           loader can accept a pixel
//  ram_addr_a   out  ADDR_WIDTH  RAM port a address (even pixel index)
//  ram_addr_b   out  ADDR_WIDTH  RAM port b address (odd pixel index)
//  ram_data_a   out  DATA_WIDTH  RAM port a write data
//  ram_data_b   out  DATA_WIDTH  RAM port b write data
//  ram_wren_a   out  1           RAM port a write enable
//  ram_wren_b   out  1           RAM port b write enable
//  load_done    out  1           1-cycle pulse: last frame word written
//  net_enable   out  1           enable to the layer control chain; level
//  net_done     in   1           done pulse from the final layer
// BEHAVIOUR
//  Reset: all outputs 0; FSM to IDLE; pixel counter and hold register cleared.
//  FSM: IDLE -start-> FILL -last pixel accepted-> FLUSH -> RUN -net_done-> IDLE.
//  - IDLE: pix_ready=0. start is sampled; counter cleared on entry to FILL.
//  - FILL: pix_ready=1. Accept occurs when pix_valid&pix_ready.
//    Even index 2k: data stored in the hold register, no write.
//    Odd index 2k+1: next cycle, ram_wren_a=ram_wren_b=1, addr_a=2k, addr_b=2k+1,
//    data_a=hold, data_b=pixel. Write latency is exactly 1 cycle after accept.
//    All RAM outputs are registered. wren is 0 in every cycle with no pair to write.
//  - Last pixel (index NUM_PIXELS-1) accepted: pix_ready drops the next cycle.
//    If NUM_PIXELS is odd, the final write has ram_wren_a=1 only (addr 2k) and ram_wren_b=0.
//  - FLUSH: single cycle carrying the final write. load_done=1 in this same cycle.
//  - RUN: net_enable=1 from the cycle after FLUSH. It stays high until net_done is sampled
//    high, then drops the next cycle and the FSM returns to IDLE. pix_ready=0.
//  - start outside IDLE is ignored. net_done outside RUN is ignored.
//  - pix_valid gaps are allowed mid-pair; the hold register keeps its value.
//  - Counter is ADDR_WIDTH+1 bits. It never wraps within a frame; it is cleared at start.
//  - Reset mid-operation (any state) aborts the frame; the partial RAM contents are don't-care.
//    Reset wins over simultaneous start/net_done.
//  - Addresses never exceed NUM_PIXELS-1. When wren=0, addr/data are held at their last values.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: adds output frame_sum [DATA_WIDTH-1:0].
//    frame_sum is the mod-2**DATA_WIDTH sum of the accepted pixels of the current frame.
//    Cleared at start. Valid and stable from the load_done cycle until the next start.
//    Reset value 0.
//  Undefined: the port and adder are absent; all other behaviour is identical.
// TESTING
//  1. NUM_PIXELS=4, pixels 1,2,3,4 back-to-back ->
//     writes (0:1,1:2) and (2:3,3:4) one cycle after each odd accept;
//     load_done on the 2nd write; net_enable the next cycle.
//  2. NUM_PIXELS=5, pixels 10..14 -> last write: wren_a=1, addr_a=4, data_a=14, wren_b=0.
//  3. pix_valid toggled 1,0,0,1 for one pair ->
//     single paired write one cycle after the 2nd accept; no spurious wren.
//  4. Reset asserted mid-FILL after 3 pixels, then a new start with 4 pixels ->
//     outputs 0 after reset; new frame is written at addresses 0..3.
//  5. In RUN, start pulse (ignored), then net_done pulse ->
//     net_enable falls 1 cycle later; FSM back in IDLE; pix_ready=0.
//  6. LOADER_CHECKSUM_EN, pixels 0xFFFF,0x0002 -> frame_sum=0x0001 at load_done.

Source files
------------

// File: rtl/in_feature_loader.sv
// in_feature_loader: accepts one frame as a valid/ready pixel stream and packs
// even/odd pixel pairs into the dual-port in_feature RAM (a = even, b = odd).
// After the final word is written it holds net_enable until net_done.
// Optional feature macro: LOADER_CHECKSUM_EN adds frame_sum (mod-2**DATA_WIDTH
// sum of the accepted pixels of the current frame).
module in_feature_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_PIXELS = 400
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic [DATA_WIDTH-1:0] ram_data_b,
  output logic                  ram_wren_a,
  output logic                  ram_wren_b,
  output logic                  load_done,
  output logic                  net_enable,
  input  logic                  net_done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] frame_sum
`endif
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH, S_RUN} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] hold;
  logic                  accept, last_acc;
  logic [ADDR_WIDTH-1:0] idx, pair_base;

  assign accept    = pix_valid & pix_ready;
  assign last_acc  = accept & (cnt == LAST_IDX);
  assign idx       = cnt[ADDR_WIDTH-1:0];
  assign pair_base = idx & ~ADDR_WIDTH'(1);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and level outputs
  always_comb begin
    state_nxt  = state;
    pix_ready  = 1'b0;
    net_enable = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FILL;
      S_FILL: begin
        pix_ready = 1'b1;
        if (last_acc) state_nxt = S_FLUSH;
      end
      S_FLUSH: state_nxt = S_RUN;
      S_RUN: begin
        net_enable = 1'b1;
        if (net_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pixel counter, hold register and registered RAM write port
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      hold       <= '0;
      ram_addr_a <= '0;
      ram_addr_b <= '0;
      ram_data_a <= '0;
      ram_data_b <= '0;
      ram_wren_a <= 1'b0;
      ram_wren_b <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      ram_wren_a <= 1'b0;
      ram_wren_b <= 1'b0;
      load_done  <= last_acc;
      if (state == S_IDLE && start) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + CW'(1);
        if (!cnt[0]) begin
          // even pixel: park it; only an odd-sized frame's tail writes alone
          hold <= pix_data;
          if (last_acc) begin
            ram_wren_a <= 1'b1;
            ram_addr_a <= idx;
            ram_data_a <= pix_data;
          end
        end else begin
          ram_wren_a <= 1'b1;
          ram_wren_b <= 1'b1;
          ram_addr_a <= pair_base;
          ram_addr_b <= idx;
          ram_data_a <= hold;
          ram_data_b <= pix_data;
        end
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of the accepted pixels; restarts with each frame
  always_ff @(posedge clock) begin
    if (reset)                        frame_sum <= '0;
    else if (state == S_IDLE && start) frame_sum <= '0;
    else if (accept)                  frame_sum <= frame_sum + pix_data;
  end
`endif

endmodule

// File: tb/tb_in_feature_loader.sv
// Bench for in_feature_loader: two instances (4-pixel and 5-pixel frames),
// expected RAM writes queued at drive time and popped by a write monitor.
module tb_in_feature_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start4, start5, pix_valid, net_done;
  logic [15:0] pix_data;

  logic        r4, w4a, w4b, ld4, ne4;
  logic [8:0]  a4a, a4b;
  logic [15:0] d4a, d4b;
  logic        r5, w5a, w5b, ld5, ne5;
  logic [8:0]  a5a, a5b;
  logic [15:0] d5a, d5b;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] s4, s5;
`endif

  in_feature_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(9), .NUM_PIXELS(4)) u4 (
    .clock(clk), .reset(reset), .start(start4), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(r4), .ram_addr_a(a4a), .ram_addr_b(a4b), .ram_data_a(d4a), .ram_data_b(d4b),
    .ram_wren_a(w4a), .ram_wren_b(w4b), .load_done(ld4), .net_enable(ne4), .net_done(net_done)
`ifdef LOADER_CHECKSUM_EN
    , .frame_sum(s4)
`endif
  );

  in_feature_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(9), .NUM_PIXELS(5)) u5 (
    .clock(clk), .reset(reset), .start(start5), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(r5), .ram_addr_a(a5a), .ram_addr_b(a5b), .ram_data_a(d5a), .ram_data_b(d5b),
    .ram_wren_a(w5a), .ram_wren_b(w5b), .load_done(ld5), .net_enable(ne5), .net_done(net_done)
`ifdef LOADER_CHECKSUM_EN
    , .frame_sum(s5)
`endif
  );

  typedef struct packed {
    int unsigned cyc;
    logic        dut;
    logic        wa, wb;
    logic [8:0]  aa, ab;
    logic [15:0] da, db;
  } wr_t;

  wr_t         sb[$];
  int          n_tests = 0, n_fail = 0;
  int unsigned cyc = 0;

  // reference model state per instance
  int          nump[2] = '{4, 5};
  int          m_idx[2];
  logic [15:0] m_hold[2], m_sum[2], lab_d[2];
  logic [8:0]  lab[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_wr(logic d, logic wa, logic wb, logic [8:0] aa, logic [8:0] ab,
                          logic [15:0] da, logic [15:0] db);
    wr_t g, e;
    g = '{cyc: cyc, dut: d, wa: wa, wb: wb, aa: aa, ab: ab, da: da, db: db};
    if (sb.size() == 0) chk("unexpected_write", 128'(g), 128'(0));
    else begin
      e = sb.pop_front();
      chk("ram_write", 128'(g), 128'(e));
    end
  endtask

  // write monitor: every asserted wren must match the head of the scoreboard
  always @(negedge clk) begin
    if (w4a || w4b) check_wr(1'b0, w4a, w4b, a4a, a4b, d4a, d4b);
    if (w5a || w5b) check_wr(1'b1, w5a, w5b, a5a, a5b, d5a, d5b);
  end

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_idx[i] = 0; m_hold[i] = '0; m_sum[i] = '0; lab[i] = '0; lab_d[i] = '0;
    end
  endtask

  // one stimulus cycle from negedge to negedge; model updated on accept
  task automatic pix(int d, bit v, logic [15:0] val);
    logic rdy;
    pix_valid = v;
    pix_data  = val;
    rdy = (d == 0) ? r4 : r5;
    if (v && rdy) begin
      if (m_idx[d] % 2 == 0) begin
        m_hold[d] = val;
        if (m_idx[d] == nump[d] - 1)
          sb.push_back('{cyc: cyc + 1, dut: 1'(d), wa: 1'b1, wb: 1'b0, aa: 9'(m_idx[d]),
                         ab: lab[d], da: val, db: lab_d[d]});
      end else begin
        sb.push_back('{cyc: cyc + 1, dut: 1'(d), wa: 1'b1, wb: 1'b1, aa: 9'(m_idx[d] - 1),
                       ab: 9'(m_idx[d]), da: m_hold[d], db: val});
        lab[d] = 9'(m_idx[d]); lab_d[d] = val;
      end
      m_idx[d]++;
      m_sum[d] = m_sum[d] + val;
    end
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic start_pulse(int d, bit idle);
    if (d == 0) start4 = 1'b1; else start5 = 1'b1;
    if (idle) begin m_idx[d] = 0; m_sum[d] = '0; end
    @(negedge clk);
    start4 = 1'b0; start5 = 1'b0;
  endtask

  task automatic done_pulse();
    net_done = 1'b1;
    @(negedge clk);
    net_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start4 = 0; start5 = 0; pix_valid = 0; pix_data = '0; net_done = 0;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset4", {r4, ne4, ld4, w4a, w4b, a4a, a4b, d4a, d4b}, 0);
    chk("reset5", {r5, ne5, ld5, w5a, w5b, a5a, a5b, d5a, d5b}, 0);
    @(negedge clk);
    chk("idle_ready", r4, 0);

    // 1: four back-to-back pixels
    start_pulse(0, 1);
    chk("fill_ready", r4, 1);
    pix(0, 1, 16'd1); pix(0, 1, 16'd2); pix(0, 1, 16'd3); pix(0, 1, 16'd4);
    chk("t1_load_done", {ld4, r4, ne4}, 3'b100);
    @(negedge clk);
    chk("t1_run", {ld4, r4, ne4}, 3'b001);
`ifdef LOADER_CHECKSUM_EN
    chk("t1_sum", s4, m_sum[0]);
`endif

    // 5: start ignored in RUN, net_done ends the run
    start_pulse(0, 0);
    chk("t5_start_ignored", {ne4, r4}, 2'b10);
    done_pulse();
    chk("t5_idle", {ne4, r4}, 2'b00);
    @(negedge clk);
    chk("t5_still_idle", {ne4, r4, ld4}, 3'b000);

    // 3: valid gaps mid-pair
    start_pulse(0, 1);
    pix(0, 1, 16'h5); pix(0, 0, 16'hDEAD); pix(0, 0, 16'hBEEF); pix(0, 1, 16'h6);
    pix(0, 1, 16'h7); pix(0, 0, 16'h0); pix(0, 1, 16'h8);
    chk("t3_load_done", {ld4, r4}, 2'b10);
    @(negedge clk);
    chk("t3_run", ne4, 1);
    done_pulse();

    // 6: checksum wrap frame
    start_pulse(0, 1);
    pix(0, 1, 16'hFFFF); pix(0, 1, 16'h0002); pix(0, 1, 16'h0); pix(0, 1, 16'h0);
    chk("t6_load_done", ld4, 1);
`ifdef LOADER_CHECKSUM_EN
    chk("t6_sum", s4, 16'h0001);
`endif
    @(negedge clk);
    done_pulse();

    // 4: reset mid-FILL, then a fresh frame
    start_pulse(0, 1);
    pix(0, 1, 16'h11); pix(0, 1, 16'h12); pix(0, 1, 16'h13);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    chk("t4_reset", {r4, ne4, ld4, w4a, w4b, a4a, a4b, d4a, d4b}, 0);
    start_pulse(0, 1);
    pix(0, 1, 16'h21); pix(0, 1, 16'h22); pix(0, 1, 16'h23); pix(0, 1, 16'h24);
    chk("t4_load_done", ld4, 1);
    @(negedge clk);
    chk("t4_run", ne4, 1);
    done_pulse();

    // 2: odd-sized frame, tail written on port a only
    start_pulse(1, 1);
    for (int i = 0; i < 5; i++) pix(1, 1, 16'(10 + i));
    chk("t2_load_done", {ld5, r5}, 2'b10);
    @(negedge clk);
    chk("t2_run", ne5, 1);
`ifdef LOADER_CHECKSUM_EN
    chk("t2_sum", s5, 16'd60);
`endif
    done_pulse();
    chk("t2_idle", ne5, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
